// File: rtl/jtag_dtm_pkg.sv
// Shared types and constants for the JTAG debug transport module.
// JTAG_DTM_IDCODE_EN selects whether the IDCODE register exists.
package jtag_dtm_pkg;

    typedef enum logic [3:0] {
        StTestLogicReset, StRunTestIdle,
        StSelectDrScan, StCaptureDr, StShiftDr, StExit1Dr, StPauseDr, StExit2Dr, StUpdateDr,
        StSelectIrScan, StCaptureIr, StShiftIr, StExit1Ir, StPauseIr, StExit2Ir, StUpdateIr
    } tap_state_e;

    typedef enum logic [1:0] {SelBypass, SelIdcode, SelDtmcs, SelDmi} dr_sel_e;

    localparam logic [4:0] IrIdcode  = 5'h01;
    localparam logic [4:0] IrDtmcs   = 5'h10;
    localparam logic [4:0] IrDmi     = 5'h11;
    localparam logic [4:0] IrBypass  = 5'h1f;
    localparam logic [4:0] IrCapture = 5'b00001;

`ifdef JTAG_DTM_IDCODE_EN
    localparam logic [4:0] IrReset = IrIdcode;
`else
    localparam logic [4:0] IrReset = IrBypass;
`endif

    localparam logic [1:0] DmiOpNop   = 2'd0;
    localparam logic [1:0] DmiOpRead  = 2'd1;
    localparam logic [1:0] DmiOpWrite = 2'd2;

    localparam logic [1:0] DmiStatOk     = 2'd0;
    localparam logic [1:0] DmiStatFailed = 2'd2;
    localparam logic [1:0] DmiStatBusy   = 2'd3;

    localparam int unsigned DtmcsDmiResetBit  = 16;
    localparam int unsigned DtmcsHardResetBit = 17;

    localparam logic [3:0] DtmVersion = 4'd1;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: state register plus decoded per-state strobes.
module jtag_tap_fsm
    import jtag_dtm_pkg::*;
(
    input  logic tck,
    input  logic trst_n,
    input  logic tms,
    output logic tlr,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir,
    output logic is_shift
);

    tap_state_e state_q, state_d;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) state_q <= StTestLogicReset;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTestLogicReset: state_d = tms ? StTestLogicReset : StRunTestIdle;
            StRunTestIdle:    state_d = tms ? StSelectDrScan   : StRunTestIdle;
            StSelectDrScan:   state_d = tms ? StSelectIrScan   : StCaptureDr;
            StCaptureDr:      state_d = tms ? StExit1Dr        : StShiftDr;
            StShiftDr:        state_d = tms ? StExit1Dr        : StShiftDr;
            StExit1Dr:        state_d = tms ? StUpdateDr       : StPauseDr;
            StPauseDr:        state_d = tms ? StExit2Dr        : StPauseDr;
            StExit2Dr:        state_d = tms ? StUpdateDr       : StShiftDr;
            StUpdateDr:       state_d = tms ? StSelectDrScan   : StRunTestIdle;
            StSelectIrScan:   state_d = tms ? StTestLogicReset : StCaptureIr;
            StCaptureIr:      state_d = tms ? StExit1Ir        : StShiftIr;
            StShiftIr:        state_d = tms ? StExit1Ir        : StShiftIr;
            StExit1Ir:        state_d = tms ? StUpdateIr       : StPauseIr;
            StPauseIr:        state_d = tms ? StExit2Ir        : StPauseIr;
            StExit2Ir:        state_d = tms ? StUpdateIr       : StShiftIr;
            StUpdateIr:       state_d = tms ? StSelectDrScan   : StRunTestIdle;
            default:          state_d = StTestLogicReset;
        endcase
    end

    // Strobes mark the state during which the next rising edge performs the action.
    always_comb begin
        tlr        = (state_q == StTestLogicReset);
        capture_dr = (state_q == StCaptureDr);
        shift_dr   = (state_q == StShiftDr);
        update_dr  = (state_q == StUpdateDr);
        capture_ir = (state_q == StCaptureIr);
        shift_ir   = (state_q == StShiftIr);
        update_ir  = (state_q == StUpdateIr);
        is_shift   = shift_dr | shift_ir;
    end

endmodule

// File: rtl/jtag_dtm_tap.sv
// RISC-V DTM front end: TAP, IR, IDCODE/DTMCS/DMI/BYPASS registers, DMI request issue.
// IDCODE register present only when JTAG_DTM_IDCODE_EN is defined.
module jtag_dtm_tap
    import jtag_dtm_pkg::*;
#(
    parameter int unsigned ABITS      = 7,
    parameter logic [31:0] IDCODE_VAL = 32'h00000001,
    parameter logic [2:0]  IDLE_HINT  = 3'd5
) (
    input  logic             jtag_tck,
    input  logic             jtag_trst_n,
    input  logic             jtag_tms,
    input  logic             jtag_tdi,
    output logic             jtag_tdo,
    output logic             jtag_tdo_en,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_resp
);

    localparam int unsigned DrW = ABITS + 34;

    logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, is_shift;

    jtag_tap_fsm u_tap_fsm (
        .tck        (jtag_tck),
        .trst_n     (jtag_trst_n),
        .tms        (jtag_tms),
        .tlr        (tlr),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .is_shift   (is_shift)
    );

    logic [4:0]       ir_q, ir_shift_q;
    logic [DrW-1:0]   dr_q, dr_d;
    dr_sel_e          sel;
    logic             busy_q, busy_d, req_valid_q, req_valid_d;
    logic [1:0]       dmistat_q, dmistat_d, req_op_q, req_op_d;
    logic [ABITS-1:0] req_addr_q, req_addr_d, last_addr_q, last_addr_d;
    logic [31:0]      req_data_q, req_data_d, resp_data_q, resp_data_d;

    always_ff @(posedge jtag_tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) begin
            ir_q       <= IrReset;
            ir_shift_q <= '0;
        end else begin
            if (tlr)            ir_q <= IrReset;
            else if (update_ir) ir_q <= ir_shift_q;
            if (capture_ir)     ir_shift_q <= IrCapture;
            else if (shift_ir)  ir_shift_q <= {jtag_tdi, ir_shift_q[4:1]};
        end
    end

    always_comb begin
        unique case (ir_q)
            IrDtmcs: sel = SelDtmcs;
            IrDmi:   sel = SelDmi;
`ifdef JTAG_DTM_IDCODE_EN
            IrIdcode: sel = SelIdcode;
`endif
            default: sel = SelBypass;
        endcase
    end

    logic [31:0]    dtmcs_cap;
    logic [DrW-1:0] dmi_cap;
    assign dtmcs_cap = {14'b0, 2'b0, 1'b0, IDLE_HINT, dmistat_q, 6'(ABITS), DtmVersion};
    assign dmi_cap   = {last_addr_q, resp_data_q, busy_q ? DmiStatBusy : dmistat_q};

    always_comb begin
        dr_d = dr_q;
        if (capture_dr) begin
            dr_d = '0;
            unique case (sel)
                SelIdcode: dr_d[31:0] = IDCODE_VAL;
                SelDtmcs:  dr_d[31:0] = dtmcs_cap;
                SelDmi:    dr_d       = dmi_cap;
                SelBypass: dr_d[0]    = 1'b0;
                default:   dr_d       = '0;
            endcase
        end else if (shift_dr) begin
            unique case (sel)
                SelDmi:    dr_d       = {jtag_tdi, dr_q[DrW-1:1]};
                SelBypass: dr_d[0]    = jtag_tdi;
                default:   dr_d[31:0] = {jtag_tdi, dr_q[31:1]};
            endcase
        end
    end

    always_ff @(posedge jtag_tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) dr_q <= '0;
        else              dr_q <= dr_d;
    end

    always_ff @(negedge jtag_tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) begin
            jtag_tdo    <= 1'b0;
            jtag_tdo_en <= 1'b0;
        end else begin
            jtag_tdo_en <= is_shift;
            if (shift_ir)      jtag_tdo <= ir_shift_q[0];
            else if (shift_dr) jtag_tdo <= dr_q[0];
        end
    end

    logic [1:0]       upd_op;
    logic [31:0]      upd_data;
    logic [ABITS-1:0] upd_addr;
    assign upd_op   = dr_q[1:0];
    assign upd_data = dr_q[33:2];
    assign upd_addr = dr_q[DrW-1:34];

    always_comb begin
        busy_d      = busy_q;
        req_valid_d = req_valid_q;
        dmistat_d   = dmistat_q;
        req_op_d    = req_op_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        last_addr_d = last_addr_q;
        resp_data_d = resp_data_q;

        if (req_valid_q && dmi_req_ready) req_valid_d = 1'b0;

        // Response is absorbed before any same-edge DMI update, which still sees busy_q.
        if (dmi_resp_valid && busy_q) begin
            resp_data_d = dmi_resp_data;
            if (dmi_resp_resp != DmiStatOk) dmistat_d = dmi_resp_resp;
            busy_d = 1'b0;
        end

        if (update_dr && sel == SelDtmcs) begin
            if (dr_q[DtmcsDmiResetBit]) dmistat_d = DmiStatOk;
            if (dr_q[DtmcsHardResetBit]) begin
                busy_d      = 1'b0;
                req_valid_d = 1'b0;
            end
        end else if (update_dr && sel == SelDmi) begin
            if (busy_q) begin
                dmistat_d = DmiStatBusy;
            end else if (dmistat_q == DmiStatOk &&
                         (upd_op == DmiOpRead || upd_op == DmiOpWrite)) begin
                req_valid_d = 1'b1;
                busy_d      = 1'b1;
                req_op_d    = upd_op;
                req_addr_d  = upd_addr;
                req_data_d  = upd_data;
                last_addr_d = upd_addr;
            end
        end
    end

    always_ff @(posedge jtag_tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) begin
            busy_q      <= 1'b0;
            req_valid_q <= 1'b0;
            dmistat_q   <= DmiStatOk;
            req_op_q    <= DmiOpNop;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            last_addr_q <= '0;
            resp_data_q <= '0;
        end else begin
            busy_q      <= busy_d;
            req_valid_q <= req_valid_d;
            dmistat_q   <= dmistat_d;
            req_op_q    <= req_op_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            last_addr_q <= last_addr_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign dmi_req_valid  = req_valid_q;
    assign dmi_req_addr   = req_addr_q;
    assign dmi_req_data   = req_data_q;
    assign dmi_req_op     = req_op_q;
    assign dmi_resp_ready = busy_q;

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Directed bench for jtag_dtm_tap; expectations follow JTAG_DTM_IDCODE_EN when defined.
module tb_jtag_dtm_tap;

    logic        jtag_tck = 1'b0;
    logic        jtag_trst_n, jtag_tms, jtag_tdi;
    logic        jtag_tdo, jtag_tdo_en;
    logic        dmi_req_valid, dmi_req_ready;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_resp_valid, dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic [1:0]  dmi_resp_resp;

    int checks = 0;
    int errors = 0;

    always #5 jtag_tck = ~jtag_tck;

    jtag_dtm_tap dut (
        .jtag_tck       (jtag_tck),
        .jtag_trst_n    (jtag_trst_n),
        .jtag_tms       (jtag_tms),
        .jtag_tdi       (jtag_tdi),
        .jtag_tdo       (jtag_tdo),
        .jtag_tdo_en    (jtag_tdo_en),
        .dmi_req_valid  (dmi_req_valid),
        .dmi_req_ready  (dmi_req_ready),
        .dmi_req_addr   (dmi_req_addr),
        .dmi_req_data   (dmi_req_data),
        .dmi_req_op     (dmi_req_op),
        .dmi_resp_valid (dmi_resp_valid),
        .dmi_resp_ready (dmi_resp_ready),
        .dmi_resp_data  (dmi_resp_data),
        .dmi_resp_resp  (dmi_resp_resp)
    );

    typedef struct {
        string       name;
        logic [4:0]  ir;
        logic [63:0] din;
        int          n;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic tms, input logic tdi);
        jtag_tms = tms;
        jtag_tdi = tdi;
        @(posedge jtag_tck);
        #1;
    endtask

    // Entered in a shift state; leaves in Exit1. TDO is sampled just after each falling edge.
    task automatic shift(input logic [63:0] din, input int n, output logic [63:0] dout,
                         output logic en_ok);
        dout  = '0;
        en_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            jtag_tdi = din[i];
            jtag_tms = (i == n - 1);
            @(negedge jtag_tck);
            #1;
            dout[i] = jtag_tdo;
            if (jtag_tdo_en !== 1'b1) en_ok = 1'b0;
            @(posedge jtag_tck);
            #1;
        end
    endtask

    task automatic goto_shift_dr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic dr_scan(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic en_ok;
        goto_shift_dr();
        shift(din, n, dout, en_ok);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic ir_scan(input logic [4:0] ir);
        logic [63:0] dout;
        logic        en_ok;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        shift({59'b0, ir}, 5, dout, en_ok);
        check("ir_capture", dout, 64'h1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                             input logic [1:0] s);
        return {23'b0, a, d, s};
    endfunction

    initial begin
        logic [63:0] dout;
        logic        en_ok;
        logic        seen;

        vecs[0] = '{"dtmcs_capture", 5'h10, 64'h0, 32, 64'h5071};
        vecs[1] = '{"bypass_1f", 5'h1f, 64'hA5, 8, 64'h4A};
        vecs[2] = '{"bypass_05", 5'h05, 64'h3C, 8, 64'h78};
`ifdef JTAG_DTM_IDCODE_EN
        vecs[3] = '{"idcode_ir01", 5'h01, 64'h0, 32, 64'h1};
`else
        vecs[3] = '{"ir01_bypass", 5'h01, 64'hF0, 8, 64'hE0};
`endif
        vecs[4] = '{"dmi_idle_capture", 5'h11, 64'h0, 41, 64'h0};

        jtag_trst_n    = 1'b1;
        jtag_tms       = 1'b1;
        jtag_tdi       = 1'b0;
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp_data  = '0;
        dmi_resp_resp  = '0;
        #1 jtag_trst_n = 1'b0;
        #10;
        check("reset_outputs", {60'b0, jtag_tdo, jtag_tdo_en, dmi_req_valid, dmi_resp_ready},
              64'h0);
        #7 jtag_trst_n = 1'b1;

        // First scan after reset: IDCODE when present, else BYPASS with one-bit delay.
        step(1'b0, 1'b0);
        goto_shift_dr();
`ifdef JTAG_DTM_IDCODE_EN
        shift(64'h0, 32, dout, en_ok);
        check("reset_idcode", dout, 64'h1);
`else
        shift(64'hB6, 8, dout, en_ok);
        check("reset_bypass", dout, 64'h6C);
`endif
        check("tdo_en_shift", {63'b0, en_ok}, 64'h1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("tdo_en_idle", {63'b0, jtag_tdo_en}, 64'h0);

        for (int i = 0; i < 5; i++) begin
            ir_scan(vecs[i].ir);
            dr_scan(vecs[i].din, vecs[i].n, dout);
            check(vecs[i].name, dout, vecs[i].exp);
        end

        // Read request with ready already high: single-cycle valid.
        dmi_req_ready = 1'b1;
        dr_scan(dmi_word(7'h10, 32'h0, 2'd1), 41, dout);
        check("dmi_req_launch", {dmi_req_valid, 21'b0, dmi_req_addr, dmi_req_data, dmi_req_op},
              {1'b1, 21'b0, 7'h10, 32'h0, 2'd1});
        step(1'b0, 1'b0);
        check("dmi_req_drop", {63'b0, dmi_req_valid}, 64'h0);
        check("busy_set", {63'b0, dmi_resp_ready}, 64'h1);
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'hDEADBEEF;
        dmi_resp_resp  = 2'd0;
        step(1'b0, 1'b0);
        dmi_resp_valid = 1'b0;
        check("busy_clear", {63'b0, dmi_resp_ready}, 64'h0);
        dr_scan(64'h0, 41, dout);
        check("dmi_read_data", dout, dmi_word(7'h10, 32'hDEADBEEF, 2'd0));

        // Write held by ready=0, then a second update while busy.
        dmi_req_ready = 1'b0;
        dr_scan(dmi_word(7'h22, 32'h12345678, 2'd2), 41, dout);
        check("dmi_cap_before_wr", dout, dmi_word(7'h10, 32'hDEADBEEF, 2'd0));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("dmi_wr_held", {dmi_req_valid, 21'b0, dmi_req_addr, dmi_req_data, dmi_req_op},
              {1'b1, 21'b0, 7'h22, 32'h12345678, 2'd2});
        dr_scan(dmi_word(7'h33, 32'h0, 2'd1), 41, dout);
        check("dmi_cap_busy", dout, dmi_word(7'h22, 32'hDEADBEEF, 2'd3));
        check("dmi_payload_stable", {dmi_req_valid, 21'b0, dmi_req_addr, dmi_req_data, dmi_req_op},
              {1'b1, 21'b0, 7'h22, 32'h12345678, 2'd2});

        ir_scan(5'h10);
        dr_scan(64'h1 << 16, 32, dout);
        check("dtmcs_sticky3", dout, 64'h5C71);
        dr_scan(64'h1 << 17, 32, dout);
        check("dtmcs_cleared", dout, 64'h5071);
        check("hardreset", {62'b0, dmi_req_valid, dmi_resp_ready}, 64'h0);

        // Response while idle must be ignored.
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h0BADF00D;
        dmi_resp_resp  = 2'd2;
        step(1'b0, 1'b0);
        dmi_resp_valid = 1'b0;
        ir_scan(5'h11);
        dr_scan(64'h0, 41, dout);
        check("resp_ignored", dout, dmi_word(7'h22, 32'hDEADBEEF, 2'd0));

        // Response accept on the same edge as a DMI update.
        dmi_req_ready = 1'b1;
        dr_scan(dmi_word(7'h05, 32'h0, 2'd1), 41, dout);
        step(1'b0, 1'b0);
        goto_shift_dr();
        shift(dmi_word(7'h06, 32'h0, 2'd1), 41, dout, en_ok);
        check("dmi_cap_pending", dout, dmi_word(7'h05, 32'hDEADBEEF, 2'd3));
        step(1'b1, 1'b0);
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'hCAFEF00D;
        dmi_resp_resp  = 2'd0;
        step(1'b0, 1'b0);
        dmi_resp_valid = 1'b0;
        check("simul_no_req", {62'b0, dmi_req_valid, dmi_resp_ready}, 64'h0);
        ir_scan(5'h10);
        dr_scan(64'h1 << 16, 32, dout);
        check("simul_sticky3", dout, 64'h5C71);
        ir_scan(5'h11);
        dr_scan(64'h0, 41, dout);
        check("simul_resp_data", dout, dmi_word(7'h05, 32'hCAFEF00D, 2'd0));

        // Five TMS=1 from Shift-DR reach Test-Logic-Reset, which reloads the reset IR.
        ir_scan(5'h10);
        goto_shift_dr();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
`ifdef JTAG_DTM_IDCODE_EN
        dr_scan(64'h0, 32, dout);
        check("tlr_idcode", dout, 64'h1);
`else
        dr_scan(64'h96, 8, dout);
        check("tlr_bypass", dout, 64'h2C);
`endif

        // Asynchronous reset in the middle of an outstanding request and a shift.
        dmi_req_ready = 1'b0;
        ir_scan(5'h11);
        dr_scan(dmi_word(7'h07, 32'hAA, 2'd2), 41, dout);
        check("pre_reset_valid", {63'b0, dmi_req_valid}, 64'h1);
        goto_shift_dr();
        jtag_tms = 1'b0;
        @(negedge jtag_tck);
        #1;
        check("pre_reset_shift", {62'b0, jtag_tdo_en, jtag_tdo}, 64'h3);
        jtag_trst_n = 1'b0;
        #1;
        check("reset_async", {61'b0, dmi_req_valid, jtag_tdo_en, jtag_tdo}, 64'h0);
        #2 jtag_trst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            if (dmi_req_valid !== 1'b0) seen = 1'b1;
        end
        check("no_req_after_reset", {63'b0, seen}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
